// File: rtl/centroid_div_seq.sv
// Sequences one centroid request through a shared pipelined divider: x/count, then y/count.
// A zero count or a missing divider result ends the request with error_out set and zeroed coordinates.
module centroid_div_seq #(
  parameter int WIDTH       = 9,
  parameter int DIV_LATENCY = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid_in,
  input  logic [WIDTH-1:0] x_num_in,
  input  logic [WIDTH-1:0] y_num_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             req_ready_out,
  output logic [WIDTH-1:0] div_dividend_out,
  output logic [WIDTH-1:0] div_divisor_out,
  output logic             div_valid_out,
  input  logic [WIDTH-1:0] div_quotient_in,
  input  logic             div_valid_in,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             result_valid_out,
  output logic             error_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE_Y, WAIT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] count_q;
  logic [1:0]       rcvd;
  logic [TW-1:0]    timer;

  // A timeout shorter than the divider round trip would fail every request.
  if (TIMEOUT < DIV_LATENCY + 3) begin : g_timeout_check
    $error("TIMEOUT is shorter than the divider round trip");
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      y_q              <= '0;
      count_q          <= '0;
      rcvd             <= '0;
      timer            <= '0;
      req_ready_out    <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
      div_valid_out    <= 1'b0;
      x_out            <= '0;
      y_out            <= '0;
      result_valid_out <= 1'b0;
      error_out        <= 1'b0;
    end else begin
      div_valid_out    <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
      result_valid_out <= 1'b0;
      error_out        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_in && req_ready_out) begin
            y_q           <= y_num_in;
            count_q       <= count_in;
            rcvd          <= '0;
            timer         <= '0;
            req_ready_out <= 1'b0;
            if (count_in == '0) begin
              state            <= DONE;
              x_out            <= '0;
              y_out            <= '0;
              result_valid_out <= 1'b1;
              error_out        <= 1'b1;
            end else begin
              state            <= ISSUE_Y;
              div_valid_out    <= 1'b1;
              div_dividend_out <= x_num_in;
              div_divisor_out  <= count_in;
            end
          end else begin
            req_ready_out <= 1'b1;
          end
        end
        ISSUE_Y: begin
          state            <= WAIT;
          timer            <= timer + TW'(1);
          div_valid_out    <= 1'b1;
          div_dividend_out <= y_q;
          div_divisor_out  <= count_q;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (rcvd == 2'd2) begin
            state            <= DONE;
            result_valid_out <= 1'b1;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state            <= DONE;
            x_out            <= '0;
            y_out            <= '0;
            result_valid_out <= 1'b1;
            error_out        <= 1'b1;
          end else if (div_valid_in) begin
            // Results return in issue order: first is x, second is y.
            if (rcvd == 2'd0) x_out <= div_quotient_in;
            else              y_out <= div_quotient_in;
            rcvd <= rcvd + 2'd1;
          end
        end
        DONE: begin
          state         <= IDLE;
          req_ready_out <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_div_seq.sv
// Drives centroid requests against a latency-4 divider model and checks results against plain arithmetic.
module tb_centroid_div_seq;
  localparam int W   = 9;
  localparam int LAT = 4;
  localparam int TO  = 15;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         req_valid_in = 1'b0;
  logic [W-1:0] x_num_in = '0, y_num_in = '0, count_in = '0;
  logic         req_ready_out;
  logic [W-1:0] div_dividend_out, div_divisor_out;
  logic         div_valid_out;
  logic [W-1:0] div_quotient_in;
  logic         div_valid_in;
  logic [W-1:0] x_out, y_out;
  logic         result_valid_out, error_out;

  centroid_div_seq #(.WIDTH(W), .DIV_LATENCY(LAT), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in),
    .x_num_in(x_num_in), .y_num_in(y_num_in), .count_in(count_in),
    .req_ready_out(req_ready_out), .div_dividend_out(div_dividend_out),
    .div_divisor_out(div_divisor_out), .div_valid_out(div_valid_out),
    .div_quotient_in(div_quotient_in), .div_valid_in(div_valid_in),
    .x_out(x_out), .y_out(y_out), .result_valid_out(result_valid_out),
    .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;
  int cyc = 0, n_req = 0, n_res = 0, idle_bad = 0, dv_base = 0;
  bit drop_y = 1'b0;
  logic [W-1:0] log_a[$], log_b[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Divider model: issued at cycle c, result visible in cycle c+LAT; can drop a request's second issue.
  logic [LAT-1:0] pv = '0;
  logic [W-1:0]   pq [LAT];
  always @(posedge clk_in) begin
    pv    <= {pv[LAT-2:0], div_valid_out && !(drop_y && (log_a.size() - dv_base) == 2)};
    pq[0] <= (div_divisor_out != 0) ? div_dividend_out / div_divisor_out : '0;
    for (int i = 1; i < LAT; i++) pq[i] <= pq[i-1];
  end
  assign div_valid_in    = pv[LAT-1];
  assign div_quotient_in = pq[LAT-1];

  always @(negedge clk_in) begin
    if (div_valid_out) begin
      log_a.push_back(div_dividend_out);
      log_b.push_back(div_divisor_out);
    end else if (div_dividend_out != 0 || div_divisor_out != 0) begin
      idle_bad <= idle_bad + 1;
    end
    if (result_valid_out) n_res <= n_res + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] c,
                         input bit drop, input bit hold);
    int n, t_acc, t_res, nd;
    logic [W-1:0] ex, ey;
    bit eerr;
    n = 0;
    while (!req_ready_out && n < 60) begin @(negedge clk_in); n++; end
    check("ready_wait", req_ready_out, 1);
    drop_y = drop;
    dv_base = log_a.size();
    req_valid_in = 1'b1; x_num_in = x; y_num_in = y; count_in = c;
    @(negedge clk_in);
    t_acc = cyc;
    check("accepted", req_ready_out, 0);
    req_valid_in = hold;
    n = 0;
    while (!result_valid_out && n < 40) begin
      x_num_in = W'($urandom); y_num_in = W'($urandom); count_in = W'($urandom);
      @(negedge clk_in); n++;
    end
    t_res = cyc;
    check("result_seen", result_valid_out, 1);
    if (c == 0)    begin ex = 0;     ey = 0;     eerr = 1'b1; end
    else if (drop) begin ex = 0;     ey = 0;     eerr = 1'b1; end
    else           begin ex = x / c; ey = y / c; eerr = 1'b0; end
    if (c == 0)      check("latency_zero", t_res - t_acc, 0);
    else if (drop)   check("latency_timeout", (t_res - t_acc >= TO) && (t_res - t_acc <= TO + 2), 1);
    else             check("latency", t_res - t_acc, LAT + 3);
    check("x_out", x_out, ex);
    check("y_out", y_out, ey);
    check("error_out", error_out, eerr);
    nd = log_a.size() - dv_base;
    check("div_issues", nd, (c == 0) ? 0 : 2);
    if (nd == 2) begin
      check("div_x_dividend", log_a[dv_base], x);
      check("div_y_dividend", log_a[dv_base+1], y);
      check("div_divisor", (log_b[dv_base] == c) && (log_b[dv_base+1] == c), 1);
    end
    n_req++;
    @(negedge clk_in);
    check("pulse_single", result_valid_out, 0);
    check("ready_after", req_ready_out, 1);
  endtask

  initial begin
    int n, res_before;
    logic [W-1:0] rc;
    rst_in = 1'b1;
    #1 rst_in = 1'b0;
    #2;
    check("rst_ready", req_ready_out, 0);
    check("rst_outputs", {div_valid_out, div_dividend_out, div_divisor_out, x_out, y_out,
                          result_valid_out, error_out}, 0);
    @(negedge clk_in); @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("ready_first_edge", req_ready_out, 1);

    run_req(100, 50, 10, 0, 0);
    run_req(37, 21, 0, 0, 0);
    run_req(120, 60, 9, 1, 0);
    run_req(3, 50, 7, 0, 0);
    run_req(511, 511, 1, 0, 0);

    for (int i = 0; i < 8; i++) begin
      rc = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(1, 511));
      run_req(W'($urandom), W'($urandom), rc, 0, 0);
    end

    for (int i = 0; i < 3; i++)
      run_req(W'($urandom), W'($urandom), W'($urandom_range(1, 40)), 0, 1);
    req_valid_in = 1'b0;

    // Reset between the x and y results.
    drop_y = 1'b0;
    dv_base = log_a.size();
    req_valid_in = 1'b1; x_num_in = 200; y_num_in = 90; count_in = 7;
    @(negedge clk_in);
    req_valid_in = 1'b0;
    n = 0;
    while (!div_valid_in && n < 20) begin @(negedge clk_in); n++; end
    check("x_result_arrives", div_valid_in, 1);
    @(negedge clk_in);
    check("x_loaded_pre_reset", x_out, 200 / 7);
    res_before = n_res;
    rst_in = 1'b0;
    #1;
    check("midrst_ready", req_ready_out, 0);
    check("midrst_outputs", {div_valid_out, div_dividend_out, div_divisor_out, x_out, y_out,
                             result_valid_out, error_out}, 0);
    #1 rst_in = 1'b1;
    repeat (8) @(negedge clk_in);
    check("no_result_after_reset", n_res - res_before, 0);
    check("stray_ignored", {x_out, y_out}, 0);
    check("ready_after_reset", req_ready_out, 1);
    run_req(255, 255, 255, 0, 0);

    check("idle_bus_zero", idle_bad, 0);
    check("result_count", n_res, n_req);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
